// File: rtl/mem_packet_to_tx_pkg.sv
// Shared types and constants for the packet-buffer transmit path.
// Holds the FSM state enum, framing bytes and the CRC-32 constants and step function.
// Optional FCS generation is selected by the MEM_TX_FCS_EN macro in the users of this package.
package mem_tx_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRE   = 3'd1,
    SFD   = 3'd2,
    DATA  = 3'd3,
    FCS   = 3'd4,
    DRAIN = 3'd5,
    IFG   = 3'd6
  } tx_state_e;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;

  localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB_20E3;

  // One byte of reflected CRC-32: LSB of the byte enters first.
  function automatic logic [31:0] crc32_next(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    logic [31:0] rpoly;
    for (int i = 0; i < 32; i++) rpoly[i] = CRC32_POLY[31-i];
    c = crc ^ {24'h0, d};
    for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ rpoly) : (c >> 1);
    return c;
  endfunction

endpackage

// File: rtl/mem_packet_to_tx_if.sv
// Bundle between the packet buffer / SRAM and the transmit framer.
// master = framer side (drives pop, read strobe and the tx byte lane).
// slave  = buffer, SRAM and PHY side.
interface mem_packet_to_tx_if #(
  parameter int pDATA_WIDTH = 8,
  parameter int pLEN_WIDTH  = 16
) ();
  logic                   iempty;
  logic [pLEN_WIDTH-1:0]  ilen_pac;
  logic                   olen_ack;
  logic                   ord_en;
  logic [pDATA_WIDTH-1:0] ird_data;
  logic                   otx_en;
  logic [pDATA_WIDTH-1:0] otxd;
  logic                   obusy;
  logic                   olen_err;
  logic [15:0]            ofrm_cnt;

  modport master (
    input  iempty, ilen_pac, ird_data,
    output olen_ack, ord_en, otx_en, otxd, obusy, olen_err, ofrm_cnt
  );

  modport slave (
    output iempty, ilen_pac, ird_data,
    input  olen_ack, ord_en, otx_en, otxd, obusy, olen_err, ofrm_cnt
  );
endinterface

// File: rtl/crc32_d8.sv
// Byte-wide reflected CRC-32 accumulator (only built when MEM_TX_FCS_EN is defined).
// Latency: register updates one edge after en_i; init_i has priority over en_i.
// Backpressure: none; the caller gates en_i to the bytes that belong in the FCS.
module crc32_d8
  import mem_tx_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        init_i,
  input  logic        en_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  logic [31:0] crc_q;
  logic [31:0] crc_d;

  assign crc_d = crc32_next(crc_q, data_i);
  assign crc_o = crc_q;

  // Accumulate one byte per enabled cycle; restart from the seed between frames.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i || init_i) crc_q <= CRC32_INIT;
    else if (en_i)          crc_q <= crc_d;
  end

endmodule

// File: rtl/mem_packet_to_tx.sv
// Pops stored packets and frames them (preamble, SFD, payload, optional FCS, IFG) onto an 8-bit tx lane.
// Latency: first preamble byte one cycle after iempty=0 is sampled in IDLE; SRAM byte reaches otxd two cycles after its read strobe.
// Backpressure: none on the tx side; iempty is only sampled in IDLE. MEM_TX_FCS_EN appends a generated CRC-32.
module mem_packet_to_tx
  import mem_tx_pkg::*;
#(
  parameter int pDATA_WIDTH        = 8,
  parameter int pLEN_WIDTH         = 16,
  parameter int pMAX_PACKET_LENGHT = 1536,
  parameter int pPREAMBLE_BYTES    = 7,
  parameter int pIFG_BYTES         = 12
) (
  input  logic               iclk,
  input  logic               i_rst_n,
  mem_packet_to_tx_if.master bus
);

  localparam logic [pLEN_WIDTH-1:0] ONE      = pLEN_WIDTH'(1);
  localparam logic [pLEN_WIDTH-1:0] PRE_N    = pLEN_WIDTH'(pPREAMBLE_BYTES);
  localparam logic [pLEN_WIDTH-1:0] PRE_LAST = pLEN_WIDTH'(pPREAMBLE_BYTES - 1);
  localparam logic [pLEN_WIDTH-1:0] IFG_N    = pLEN_WIDTH'(pIFG_BYTES);
  localparam logic [pLEN_WIDTH-1:0] MAX_LEN  = pLEN_WIDTH'(pMAX_PACKET_LENGHT);

  tx_state_e              state_q;
  logic [pLEN_WIDTH-1:0]  len_q;
  logic [pLEN_WIDTH-1:0]  cnt_q;     // bytes emitted in the current state
  logic [pLEN_WIDTH-1:0]  rd_cnt_q;  // read strobes issued for the current packet
  logic                   ack_q;
  logic                   err_q;
  logic                   rd_en_q;
  logic                   tx_en_q;
  logic [pDATA_WIDTH-1:0] txd_q;
  logic                   busy_q;
  logic [15:0]            frm_q;

`ifdef MEM_TX_FCS_EN
  localparam logic [pLEN_WIDTH-1:0] FCS_N = pLEN_WIDTH'(4);
  logic [31:0] crc_w;
  logic [31:0] fcs_w;
  logic        crc_init;
  logic        crc_en;

  // CRC sees exactly the bytes captured into otxd during SFD and DATA.
  assign crc_init = (state_q == IDLE);
  assign crc_en   = (state_q == SFD) || ((state_q == DATA) && (cnt_q < len_q));
  assign fcs_w    = ~crc_w;

  crc32_d8 u_crc (
    .clk_i   (iclk),
    .rst_n_i (i_rst_n),
    .init_i  (crc_init),
    .en_i    (crc_en),
    .data_i  (bus.ird_data[7:0]),
    .crc_o   (crc_w)
  );
`endif

  // Frame sequencer; the read strobe runs alongside so SRAM data lands exactly when DATA captures it.
  always_ff @(posedge iclk) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      len_q    <= '0;
      cnt_q    <= '0;
      rd_cnt_q <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      rd_en_q  <= 1'b0;
      tx_en_q  <= 1'b0;
      txd_q    <= '0;
      busy_q   <= 1'b0;
      frm_q    <= '0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;

      // Keep the strobe up until len reads are issued, whatever the frame state.
      if (rd_en_q) begin
        if (rd_cnt_q < len_q) rd_cnt_q <= rd_cnt_q + ONE;
        else                  rd_en_q  <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (!bus.iempty) begin
            len_q  <= bus.ilen_pac;
            ack_q  <= 1'b1;
            busy_q <= 1'b1;
            cnt_q  <= ONE;
            if (bus.ilen_pac == '0) begin
              err_q   <= 1'b1;
              state_q <= IFG;
            end else if (bus.ilen_pac > MAX_LEN) begin
              err_q    <= 1'b1;
              state_q  <= DRAIN;
              rd_en_q  <= 1'b1;
              rd_cnt_q <= ONE;
            end else begin
              state_q <= PRE;
              tx_en_q <= 1'b1;
              txd_q   <= pDATA_WIDTH'(PREAMBLE_BYTE);
              if (PRE_N == ONE) begin
                rd_en_q  <= 1'b1;
                rd_cnt_q <= ONE;
              end
            end
          end
        end
        PRE: begin
          if (cnt_q < PRE_N) begin
            txd_q <= pDATA_WIDTH'(PREAMBLE_BYTE);
            cnt_q <= cnt_q + ONE;
            if (cnt_q == PRE_LAST) begin
              rd_en_q  <= 1'b1;
              rd_cnt_q <= ONE;
            end
          end else begin
            txd_q   <= pDATA_WIDTH'(SFD_BYTE);
            state_q <= SFD;
          end
        end
        SFD: begin
          state_q <= DATA;
          txd_q   <= bus.ird_data;
          cnt_q   <= ONE;
        end
        DATA: begin
          if (cnt_q < len_q) begin
            txd_q <= bus.ird_data;
            cnt_q <= cnt_q + ONE;
          end else begin
`ifdef MEM_TX_FCS_EN
            state_q <= FCS;
            txd_q   <= pDATA_WIDTH'(fcs_w[7:0]);
            cnt_q   <= ONE;
`else
            state_q <= IFG;
            tx_en_q <= 1'b0;
            txd_q   <= '0;
            cnt_q   <= ONE;
            frm_q   <= frm_q + 16'd1;
`endif
          end
        end
`ifdef MEM_TX_FCS_EN
        FCS: begin
          if (cnt_q < FCS_N) begin
            txd_q <= pDATA_WIDTH'(fcs_w[{cnt_q[1:0], 3'b000} +: 8]);
            cnt_q <= cnt_q + ONE;
          end else begin
            state_q <= IFG;
            tx_en_q <= 1'b0;
            txd_q   <= '0;
            cnt_q   <= ONE;
            frm_q   <= frm_q + 16'd1;
          end
        end
`endif
        DRAIN: begin
          if (rd_cnt_q >= len_q) begin
            state_q <= IFG;
            cnt_q   <= ONE;
          end
        end
        IFG: begin
          if (cnt_q >= IFG_N) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + ONE;
          end
        end
        default: begin
          state_q <= IDLE;
          tx_en_q <= 1'b0;
          rd_en_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.olen_ack = ack_q;
  assign bus.olen_err = err_q;
  assign bus.ord_en   = rd_en_q;
  assign bus.otx_en   = tx_en_q;
  assign bus.otxd     = txd_q;
  assign bus.obusy    = busy_q;
  assign bus.ofrm_cnt = frm_q;

endmodule

// File: tb/tb_mem_packet_to_tx.sv
// Directed bench for mem_packet_to_tx: table of single packets plus hand sequences
// for back-to-back frames, FCS (when MEM_TX_FCS_EN is defined) and reset mid-frame.
module tb_mem_packet_to_tx;

`ifdef MEM_TX_FCS_EN
  localparam int FX = 4;
`else
  localparam int FX = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_packet_to_tx_if bus ();

  mem_packet_to_tx dut (
    .iclk    (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int n_chk = 0;
  int n_fail = 0;

  // SRAM model: byte returned the cycle after the strobe is sampled.
  logic [7:0]  mem [0:8191];
  logic [12:0] addr;
  always @(posedge clk) begin
    if (!rst_n) begin
      addr <= '0;
      bus.ird_data <= '0;
    end else if (bus.ord_en) begin
      bus.ird_data <= mem[addr];
      addr <= addr + 13'd1;
    end
  end

  // Monitor: running totals, tx byte log and idle-gap log.
  logic [7:0] tx_q[$];
  int gap_q[$];
  int rd_tot = 0, ack_tot = 0, err_tot = 0, low_run = 0;
  logic prev_en = 1'b0;
  always @(negedge clk) begin
    if (bus.otx_en) begin
      tx_q.push_back(bus.otxd);
      if (!prev_en) gap_q.push_back(low_run);
      low_run = 0;
    end else begin
      low_run++;
    end
    if (bus.ord_en)   rd_tot++;
    if (bus.olen_ack) ack_tot++;
    if (bus.olen_err) err_tot++;
    prev_en = bus.otx_en;
  end

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input int len);
    int t;
    bus.iempty = 1'b0;
    bus.ilen_pac = 16'(len);
    t = 0;
    while (!bus.olen_ack && t < 200) begin tick(); t++; end
    if (!bus.olen_ack) check("ack_timeout", 0, 1);
    bus.iempty = 1'b1;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (bus.obusy && t < 5000) begin tick(); t++; end
    if (bus.obusy) check("idle_timeout", 1, 0);
  endtask

  // Count mismatches of one frame (preamble, SFD, payload) starting at tx log index 'start'.
  function automatic int frame_errs(input int start, input int len, input int ptr);
    int e;
    e = 0;
    if (tx_q.size() < start + 8 + len) return 9999;
    for (int k = 0; k < 7; k++) if (tx_q[start+k] != 8'h55) e++;
    if (tx_q[start+7] != 8'hD5) e++;
    for (int k = 0; k < len; k++) if (tx_q[start+8+k] != mem[(ptr+k) % 8192]) e++;
    return e;
  endfunction

  typedef struct {
    int len;
    int ack;
    int err;
    int rd;
    int txen;
    int frm;
  } vec_t;

  vec_t vecs[7];
  int exp_ptr = 0;

  initial begin
    int ack0, err0, rd0, tx0, frm0, g0;
    logic [7:0] msg [9];

    vecs[0] = '{len: 64,   ack: 1, err: 0, rd: 64,   txen: 72 + FX,   frm: 1};
    vecs[1] = '{len: 1,    ack: 1, err: 0, rd: 1,    txen: 9 + FX,    frm: 1};
    vecs[2] = '{len: 0,    ack: 1, err: 1, rd: 0,    txen: 0,         frm: 0};
    vecs[3] = '{len: 1536, ack: 1, err: 0, rd: 1536, txen: 1544 + FX, frm: 1};
    vecs[4] = '{len: 1537, ack: 1, err: 1, rd: 1537, txen: 0,         frm: 0};
    vecs[5] = '{len: 1600, ack: 1, err: 1, rd: 1600, txen: 0,         frm: 0};
    vecs[6] = '{len: 64,   ack: 1, err: 0, rd: 64,   txen: 72 + FX,   frm: 1};

    for (int i = 0; i < 8192; i++) mem[i] = i[7:0];
    bus.iempty = 1'b1;
    bus.ilen_pac = '0;

    // Reset state
    repeat (3) tick();
    check("rst_otx_en",   int'(bus.otx_en), 0);
    check("rst_ord_en",   int'(bus.ord_en), 0);
    check("rst_olen_ack", int'(bus.olen_ack), 0);
    check("rst_olen_err", int'(bus.olen_err), 0);
    check("rst_obusy",    int'(bus.obusy), 0);
    check("rst_otxd",     int'(bus.otxd), 0);
    check("rst_ofrm_cnt", int'(bus.ofrm_cnt), 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Table of single packets
    for (int i = 0; i < 7; i++) begin
      ack0 = ack_tot; err0 = err_tot; rd0 = rd_tot; tx0 = tx_q.size(); frm0 = int'(bus.ofrm_cnt);
      send(vecs[i].len);
      wait_idle();
      tick();
      check($sformatf("v%0d_ack", i),  ack_tot - ack0, vecs[i].ack);
      check($sformatf("v%0d_err", i),  err_tot - err0, vecs[i].err);
      check($sformatf("v%0d_rd", i),   rd_tot - rd0,   vecs[i].rd);
      check($sformatf("v%0d_txen", i), tx_q.size() - tx0, vecs[i].txen);
      check($sformatf("v%0d_frm", i),  int'(bus.ofrm_cnt) - frm0, vecs[i].frm);
      if (vecs[i].txen > 0)
        check($sformatf("v%0d_data", i), frame_errs(tx0, vecs[i].len, exp_ptr), 0);
      exp_ptr = (exp_ptr + vecs[i].len) % 8192;
    end

    // Back-to-back: two queued packets, 60 then 100
    ack0 = ack_tot; tx0 = tx_q.size(); frm0 = int'(bus.ofrm_cnt); g0 = gap_q.size();
    send(60);
    bus.iempty = 1'b0;
    bus.ilen_pac = 16'd100;
    tick();
    begin
      int t;
      t = 0;
      while (!bus.olen_ack && t < 300) begin tick(); t++; end
      if (!bus.olen_ack) check("b2b_ack2_timeout", 0, 1);
    end
    bus.iempty = 1'b1;
    wait_idle();
    tick();
    check("b2b_ack", ack_tot - ack0, 2);
    check("b2b_frm", int'(bus.ofrm_cnt) - frm0, 2);
    check("b2b_txen", tx_q.size() - tx0, 68 + 108 + 2 * FX);
    check("b2b_gaps", gap_q.size() - g0, 2);
    check("b2b_gap_len", (gap_q.size() > 0) ? gap_q[gap_q.size()-1] : -1, 13);
    check("b2b_f1_data", frame_errs(tx0, 60, exp_ptr), 0);
    check("b2b_f2_data", frame_errs(tx0 + 68 + FX, 100, (exp_ptr + 60) % 8192), 0);
    exp_ptr = (exp_ptr + 160) % 8192;

`ifdef MEM_TX_FCS_EN
    // CRC-32 of "123456789" is 0xCBF43926, sent LSB first
    msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    for (int k = 0; k < 9; k++) mem[(exp_ptr + k) % 8192] = msg[k];
    tx0 = tx_q.size();
    send(9);
    wait_idle();
    tick();
    check("fcs_txen", tx_q.size() - tx0, 21);
    check("fcs_data", frame_errs(tx0, 9, exp_ptr), 0);
    check("fcs_b0", (tx_q.size() > tx0 + 17) ? int'(tx_q[tx0+17]) : -1, 8'h26);
    check("fcs_b1", (tx_q.size() > tx0 + 18) ? int'(tx_q[tx0+18]) : -1, 8'h39);
    check("fcs_b2", (tx_q.size() > tx0 + 19) ? int'(tx_q[tx0+19]) : -1, 8'hF4);
    check("fcs_b3", (tx_q.size() > tx0 + 20) ? int'(tx_q[tx0+20]) : -1, 8'hCB);
    exp_ptr = (exp_ptr + 9) % 8192;
`else
    msg = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
`endif

    // Reset at DATA byte 20 of a 200-byte frame
    tx0 = tx_q.size();
    send(200);
    begin
      int t;
      t = 0;
      while ((tx_q.size() - tx0) < 28 && t < 400) begin tick(); t++; end
      if ((tx_q.size() - tx0) < 28) check("mid_rst_timeout", tx_q.size() - tx0, 28);
    end
    rst_n = 1'b0;
    tick();
    check("mid_rst_otx_en",   int'(bus.otx_en), 0);
    check("mid_rst_ord_en",   int'(bus.ord_en), 0);
    check("mid_rst_obusy",    int'(bus.obusy), 0);
    check("mid_rst_ofrm_cnt", int'(bus.ofrm_cnt), 0);
    ack0 = ack_tot;
    tick();
    rst_n = 1'b1;
    exp_ptr = 0;
    repeat (3) tick();
    check("mid_rst_no_repop", ack_tot - ack0, 0);

    // Recovery after reset
    tx0 = tx_q.size();
    send(64);
    wait_idle();
    tick();
    check("post_rst_frm", int'(bus.ofrm_cnt), 1);
    check("post_rst_data", frame_errs(tx0, 64, exp_ptr), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_packet_to_tx.md
Name: mem_packet_to_tx

Overview:
Downstream consumer of the packet buffer. Pops one stored packet at a time and drives it onto an 8-bit MII/GMII-style transmit interface. Each frame is sent as preamble, then SFD, then the packet bytes, then an optional FCS, then the inter-frame gap. It reads the buffer's length FIFO head and issues byte-read strobes to the packet SRAM.

Parameters:
pDATA_WIDTH, 8, tx/read data width
pLEN_WIDTH, 16, width of packet length word
pMAX_PACKET_LENGHT, 1536, largest length transmitted; longer lengths are drained, not sent
pPREAMBLE_BYTES, 7, count of 0x55 bytes before SFD
pIFG_BYTES, 12, idle cycles between frames

Ports:
iclk  in  1  clock
i_rst_n  in  1  synchronous reset, active low
iempty  in  1  buffer holds no complete packet
ilen_pac  in  pLEN_WIDTH  length of head packet; valid while iempty=0
olen_ack  out  1  one-cycle pulse: head length consumed (pop)
ord_en  out  1  byte read strobe to packet SRAM
ird_data  in  pDATA_WIDTH  SRAM byte; valid the cycle after ord_en is sampled high
otx_en  out  1  transmit enable
otxd  out  pDATA_WIDTH  transmit byte
obusy  out  1  state != IDLE
olen_err  out  1  one-cycle pulse: length 0 or > pMAX_PACKET_LENGHT
ofrm_cnt  out  16  frames transmitted, wraps

Behaviour:
- Reset values: all outputs are 0 and the state is IDLE. Reset applied mid-frame drops otx_en and ord_en at the next edge, abandons the frame and does not pop the length again.
- All outputs are registered.
- Byte counter width is pLEN_WIDTH.
- Counters use unsigned compare; there is no wrap within a frame.
- FSM states: IDLE, PRE, SFD, DATA, FCS, DRAIN, IFG.
- IDLE, at edge T when iempty=0:
  - latch len = ilen_pac
  - olen_ack=1 during T+1
  - len==0: olen_err at T+1, go to IFG
  - len > pMAX_PACKET_LENGHT: olen_err at T+1, go to DRAIN
  - otherwise go to PRE
- PRE: cycles T+1..T+pPREAMBLE_BYTES, otx_en=1, otxd=0x55.
- SFD: one cycle, otxd=0xD5.
- ord_en timing: high for exactly len cycles, starting in the last PRE cycle (T+7 at default). The byte returned then appears on otxd two cycles later.
- DATA: len cycles, otx_en=1, otxd=ird_data registered. At defaults the first data byte is at T+9 and the last at T+8+len.
- FCS: see optional feature. Without it, DATA goes directly to IFG.
- DRAIN:
  - ord_en high for len cycles, otx_en=0, so the SRAM pointer stays aligned.
  - then go to IFG
  - ofrm_cnt is not incremented
- IFG: otx_en=0 and otxd=0 for pIFG_BYTES cycles, then IDLE.
  - ofrm_cnt increments on entering IFG from DATA or FCS.
  - iempty is ignored until IDLE, so back-to-back frames are separated by exactly pIFG_BYTES+1 idle cycles (includes the IDLE sampling cycle).
- iempty or ilen_pac changing mid-frame is ignored; len is latched.
- otx_en never asserts in IDLE, DRAIN or IFG.

Optional Feature:
MEM_TX_FCS_EN
- Defined:
  - CRC-32 (poly 0x04C11DB7, reflected, init 0xFFFFFFFF, final XOR) computed over the DATA bytes.
  - FCS state sends 4 bytes, LSB first, otx_en=1.
  - IFG follows.
- Undefined:
  - no FCS state and no CRC logic
  - stored packets already contain the FCS and are sent verbatim

Decomposition:
- Package mem_tx_pkg:
  - FSM state enum
  - PREAMBLE_BYTE=0x55, SFD_BYTE=0xD5
  - CRC32_POLY, CRC32_INIT, CRC32_RESIDUE
- Sub-module crc32_d8: byte-wide combinational next-CRC function plus register with init/enable. Instantiated only under MEM_TX_FCS_EN.

Test Plan:
- Single frame: iempty=0, len=64, ird_data=addr counter.
  - olen_ack one pulse
  - otxd shows 7×0x55, then 0xD5, then bytes 0..63
  - ord_en high exactly 64 cycles
  - otx_en high 72 cycles
  - ofrm_cnt=1
- Back-to-back: two queued packets, len 60 and 100 → otx_en low exactly 13 cycles between frames; second frame bytes are correct.
- len=0 → olen_err pulse, olen_ack pulse, no otx_en, no ord_en, ofrm_cnt unchanged, next packet sent after IFG.
- len=1600 → olen_err pulse, ord_en high 1600 cycles, otx_en stays 0. A following len=64 packet transmits its own bytes intact.
- Reset at DATA byte 20 of len=200 → next edge: otx_en=0, ord_en=0, obusy=0, ofrm_cnt=0.
- MEM_TX_FCS_EN, payload "123456789" (len=9) → after data, otxd=0x26,0x39,0xF4,0xCB with otx_en=1, then IFG.
